aes_inv_ark_serializer: RTL
===========================

# aes_inv_ark_serializer

Decryption-path stage directly upstream of the byte-column InvMixColumns datapath. Accepts one 128-bit cipher state plus its round key and computes AddRoundKey (state XOR key) into a holding register. Emits the result one 32-bit column per cycle, with a valid/ready handshake, in the four-byte row order the InvMixColumns column logic consumes. Carries a per-block `mix` flag so the final inverse round, which skips InvMixColumns, can travel through the same path.

## Interface
- `BYTE_W`, 8: byte width; only 8 supported.
- `NB`, 4: columns per state; only 4 supported.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: block offered.
- `in_ready`  out  1: block accepted when `in_valid & in_ready`.
- `in_state`  in  128: state; byte k (row k%4, col k/4) at `[127-8k -: 8]`.
- `in_key`  in  128: round key, same byte layout.
- `in_mix`  in  1: 1 = columns feed InvMixColumns; 0 = bypass (final round).
- `col_valid`  out  1: column presented.
- `col_ready`  in  1: column consumed when `col_valid & col_ready`.
- `col_data`  out  32: column c of (state ^ key); `[31:24]` = row 0 (`i0`) … `[7:0]` = row 3 (`i3`).
- `col_idx`  out  2: column number 0..3.
- `col_last`  out  1: high with column 3.
- `col_mix`  out  1: latched `in_mix` of the current block.

## Operation
- FSM states:
  - IDLE: `in_ready=1`, `col_valid=0`.
  - SEND: `col_valid=1`.
- IDLE, on accept:
  - `buf <= in_state ^ in_key`, `mix_q <= in_mix`, `idx <= 0`.
  - Go to SEND.
- SEND, on column handshake with idx<3: `idx <= idx+1`.
- SEND, on column handshake with idx==3:
  - If `in_valid`: accept the new block in the same cycle (`in_ready=1` only in this case) and reload `buf`, `mix_q`, `idx=0`. Stay in SEND.
  - Otherwise go to IDLE.
- `in_ready` in SEND = `(idx==3) & col_ready`. This is the only combinational input-to-output path.
- `col_data` = `buf[127-32*idx -: 32]`. `col_last` = `(idx==3)`. `col_mix` = `mix_q`. All are derived from registers only.
- XOR is bitwise over all 128 bits. Key bytes never rotate or reorder.
- `in_mix` does not change column order or data; it is only forwarded.

## Timing
- Reset values:
  - State IDLE; `in_ready=1`.
  - `col_valid=0`, `col_data=0`, `col_idx=0`, `col_last=0`, `col_mix=0`.
  - `buf=0`.
- Latency: block accepted at edge N → column 0 valid in cycle N+1. With `col_ready` held high, columns 0..3 appear in cycles N+1..N+4.
- Throughput: one block per 4 cycles with no bubble when `in_valid` is presented during column 3.
- Backpressure: while `col_valid & !col_ready`, `col_data`, `col_idx`, `col_last` and `col_mix` are held stable and `in_ready=0`.
- `in_state`, `in_key` and `in_mix` are sampled only at accept. Later changes have no effect.
- Reset mid-block: the block is dropped. Cycle after reset shows IDLE values, and no further columns of that block appear.
- Reset wins over a simultaneous handshake.

## Structure
- Shared package `aes_pkg` holds:
  - constants `AES_NB=4`, `AES_BYTE_W=8`, `AES_STATE_W=128`, `AES_COL_W=32`;
  - FSM state enum {IDLE, SEND};
  - function `aes_col(state, c)` returning column c in row-0-MSB order.
- One natural sub-module: `add_round_key`, a combinational 128-bit state ^ key, reused by the encrypt path.
- Everything else is local: FSM, 2-bit column counter, 128-bit buffer, mix flag.

## Test plan
- Reset, then accept state `00112233445566778899aabbccddeeff`, key `000102030405060708090a0b0c0d0e0f`, `in_mix=1`, `col_ready=1`:
  - Cycles 1–4 give `00102030`, `40506070`, `8090a0b0`, `c0d0e0f0`, idx 0..3.
  - `col_last` high only in cycle 4; `col_mix=1` throughout; then IDLE.
- Same block, `col_ready=0` for 3 cycles while idx=1:
  - `col_data` holds `40506070` and idx holds 1.
  - `in_ready=0` throughout the stall; no column is skipped or repeated.
- Back-to-back blocks, second with key = state and `in_mix=0`, offered during column 3:
  - Accepted in that cycle with no idle cycle.
  - Next four columns are `00000000` with `col_mix=0`.
- `in_valid` high from cycle 1 of a block with `in_state` toggling every cycle:
  - Accepted only on the column-3 handshake.
  - Emitted data matches the value present at that edge.
- `rst` pulsed while idx=2:
  - Next cycle `col_valid=0`, `in_ready=1`, all outputs at reset values.
  - The following block starts at idx 0 with correct data.
- Key all zero, state `ffffffff000000005a5a5a5aa5a5a5a5`: columns pass through unchanged, in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and column-extraction helper.
package aes_pkg;

    localparam int unsigned AES_NB      = 4;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_COL_W   = 32;

    typedef enum logic [0:0] {IDLE, SEND} aes_state_e;

    // Column c of a state, row 0 in the MSB byte.
    function automatic logic [AES_COL_W-1:0] aes_col(input logic [AES_STATE_W-1:0] state,
                                                     input logic [1:0] c);
        logic [AES_COL_W-1:0] col;
        case (c)
            2'd0:    col = state[127:96];
            2'd1:    col = state[95:64];
            2'd2:    col = state[63:32];
            default: col = state[31:0];
        endcase
        return col;
    endfunction

endpackage

// File: rtl/add_round_key.sv
// Combinational AddRoundKey: bitwise state ^ key, shared with the encrypt path.
module add_round_key
    import aes_pkg::*;
(
    input  logic [AES_STATE_W-1:0] state,
    input  logic [AES_STATE_W-1:0] key,
    output logic [AES_STATE_W-1:0] result
);

    assign result = state ^ key;

endmodule

// File: rtl/aes_inv_ark_serializer.sv
// AddRoundKey into a holding buffer, then one 32-bit column per handshake toward
// InvMixColumns; the per-block mix flag rides along unchanged.
module aes_inv_ark_serializer
    import aes_pkg::*;
#(
    parameter int unsigned BYTE_W = AES_BYTE_W,
    parameter int unsigned NB     = AES_NB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NB*NB-1:0]  in_state,
    input  logic [BYTE_W*NB*NB-1:0]  in_key,
    input  logic                     in_mix,
    output logic                     col_valid,
    input  logic                     col_ready,
    output logic [BYTE_W*NB-1:0]     col_data,
    output logic [1:0]               col_idx,
    output logic                     col_last,
    output logic                     col_mix
);

    logic [AES_STATE_W-1:0] ark;
    logic [AES_STATE_W-1:0] buf_q;
    aes_state_e             state_q;
    logic                   mix_q;
    logic [1:0]             idx_q;
    logic                   last;

    add_round_key u_add_round_key (
        .state  (in_state),
        .key    (in_key),
        .result (ark)
    );

    assign last = (idx_q == 2'd3);

    // Only combinational input-to-output path: a new block may enter on the
    // column-3 handshake so back-to-back blocks have no bubble.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            SEND: in_ready = last & col_ready;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            mix_q   <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        buf_q   <= ark;
                        mix_q   <= in_mix;
                        idx_q   <= 2'd0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (col_ready) begin
                        if (!last) begin
                            idx_q <= idx_q + 2'd1;
                        end else if (in_valid) begin
                            buf_q <= ark;
                            mix_q <= in_mix;
                            idx_q <= 2'd0;
                        end else begin
                            idx_q   <= 2'd0;
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign col_valid = (state_q == SEND);
    assign col_data  = aes_col(buf_q, idx_q);
    assign col_idx   = idx_q;
    assign col_last  = last;
    assign col_mix   = mix_q;

endmodule
